// File: rtl/hazard_ctrl_sb.sv
// rtl/hazard_ctrl_sb.sv - scoreboard-based pipeline hazard controller
module hazard_ctrl_sb #(
    parameter int REG_W        = 3,
    parameter int FWD_MODE     = 1,
    parameter int WB_BYPASS    = 1,
    parameter int JUMP_BUBBLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs,
    input  logic             dec_rs_v,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_rt_v,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rd_v,
    input  logic             dec_memread,
    input  logic             dec_jump,
    input  logic             branch_taken_e,
    input  logic             dmem_stall,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             nop_f,
    output logic             raw_stall
);

    typedef enum logic {IDLE, BUBBLE} state_e;

    // Shadow E/M/WB stages; WB's load flag is never consulted, so it is not kept.
    logic             se_v_q, se_rdv_q, se_ld_q;
    logic [REG_W-1:0] se_rd_q;
    logic             sm_v_q, sm_rdv_q, sm_ld_q;
    logic [REG_W-1:0] sm_rd_q;
    logic             sw_v_q, sw_rdv_q;
    logic [REG_W-1:0] sw_rd_q;

    logic             se_v_d, se_rdv_d, se_ld_d;
    logic [REG_W-1:0] se_rd_d;

    state_e           state_q;
    logic [1:0]       cnt_q;

    logic m_se, m_sm, m_sw, raw;
    logic p1, p2, p3, p4;

    assign m_se = dec_valid & se_v_q & se_rdv_q &
                  ((dec_rs_v & (dec_rs == se_rd_q)) | (dec_rt_v & (dec_rt == se_rd_q)));
    assign m_sm = dec_valid & sm_v_q & sm_rdv_q &
                  ((dec_rs_v & (dec_rs == sm_rd_q)) | (dec_rt_v & (dec_rt == sm_rd_q)));
    assign m_sw = dec_valid & sw_v_q & sw_rdv_q &
                  ((dec_rs_v & (dec_rs == sw_rd_q)) | (dec_rt_v & (dec_rt == sw_rd_q)));

    assign raw = (FWD_MODE != 0) ? (m_se & se_ld_q)
                                 : (m_se | m_sm | (m_sw & (WB_BYPASS == 0)));

    assign p1 = dmem_stall;
    assign p2 = ~p1 & branch_taken_e;
    assign p3 = ~p1 & ~p2 & raw;
    assign p4 = ~p1 & ~p2 & ~p3;

    assign stall_f   = rst_n & (p1 | p3);
    assign stall_d   = rst_n & (p1 | p3);
    assign flush_d   = rst_n & p2;
    assign flush_e   = rst_n & (p2 | p3);
    assign raw_stall = rst_n & p3;
    assign nop_f     = rst_n & (state_q == BUBBLE) & ~p1;

    always_comb begin
        se_v_d   = dec_valid;
        se_rd_d  = dec_rd;
        se_rdv_d = dec_rd_v;
        se_ld_d  = dec_memread;
        if (p2 | p3) begin
            se_v_d   = 1'b0;
            se_rd_d  = '0;
            se_rdv_d = 1'b0;
            se_ld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            se_v_q   <= 1'b0;
            se_rd_q  <= '0;
            se_rdv_q <= 1'b0;
            se_ld_q  <= 1'b0;
            sm_v_q   <= 1'b0;
            sm_rd_q  <= '0;
            sm_rdv_q <= 1'b0;
            sm_ld_q  <= 1'b0;
            sw_v_q   <= 1'b0;
            sw_rd_q  <= '0;
            sw_rdv_q <= 1'b0;
        end else if (!p1) begin
            sw_v_q   <= sm_v_q;
            sw_rd_q  <= sm_rd_q;
            sw_rdv_q <= sm_rdv_q;
            sm_v_q   <= se_v_q;
            sm_rd_q  <= se_rd_q;
            sm_rdv_q <= se_rdv_q;
            sm_ld_q  <= se_ld_q;
            se_v_q   <= se_v_d;
            se_rd_q  <= se_rd_d;
            se_rdv_q <= se_rdv_d;
            se_ld_q  <= se_ld_d;
        end
    end

    // Jump bubble sequencer: a jump only launches once it actually leaves D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p2) begin
                        cnt_q <= 2'd0;
                    end else if (p4 & dec_valid & dec_jump) begin
                        state_q <= BUBBLE;
                        cnt_q   <= 2'(JUMP_BUBBLES);
                    end
                end
                BUBBLE: begin
                    if (p2) begin
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                    end else if (!p1) begin
                        if (cnt_q <= 2'd1) begin
                            state_q <= IDLE;
                            cnt_q   <= 2'd0;
                        end else begin
                            cnt_q <= cnt_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb/tb_hazard_ctrl_sb.sv - directed bench for hazard_ctrl_sb (forwarding and no-forward instances)
module tb_hazard_ctrl_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_rs_v, dec_rt_v, dec_rd_v, dec_memread, dec_jump;
    logic [2:0] dec_rs, dec_rt, dec_rd;
    logic       branch_taken_e, dmem_stall;

    logic a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_nop_f, a_raw;
    logic b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_nop_f, b_raw;

    int vectors = 0;
    int miscompares = 0;

    // Output vector order: {stall_f, stall_d, flush_d, flush_e, nop_f, raw_stall}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_RAW  = 6'b110101;
    localparam logic [5:0] O_BR   = 6'b001100;
    localparam logic [5:0] O_MEM  = 6'b110000;
    localparam logic [5:0] O_NOP  = 6'b000010;

    wire [5:0] oa = {a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_nop_f, a_raw};
    wire [5:0] ob = {b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_nop_f, b_raw};

    always #5 clk = ~clk;

    hazard_ctrl_sb #(.REG_W(3), .FWD_MODE(1), .WB_BYPASS(1), .JUMP_BUBBLES(2)) u_fwd (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rs_v(dec_rs_v), .dec_rt(dec_rt), .dec_rt_v(dec_rt_v),
        .dec_rd(dec_rd), .dec_rd_v(dec_rd_v), .dec_memread(dec_memread), .dec_jump(dec_jump),
        .branch_taken_e(branch_taken_e), .dmem_stall(dmem_stall),
        .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d), .flush_e(a_flush_e),
        .nop_f(a_nop_f), .raw_stall(a_raw)
    );

    hazard_ctrl_sb #(.REG_W(3), .FWD_MODE(0), .WB_BYPASS(1), .JUMP_BUBBLES(2)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rs_v(dec_rs_v), .dec_rt(dec_rt), .dec_rt_v(dec_rt_v),
        .dec_rd(dec_rd), .dec_rd_v(dec_rd_v), .dec_memread(dec_memread), .dec_jump(dec_jump),
        .branch_taken_e(branch_taken_e), .dmem_stall(dmem_stall),
        .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d), .flush_e(b_flush_e),
        .nop_f(b_nop_f), .raw_stall(b_raw)
    );

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [2:0] rs, input logic rs_v,
                         input logic [2:0] rt, input logic rt_v,
                         input logic [2:0] rd, input logic rd_v,
                         input logic mr, input logic jmp);
        dec_valid = v;  dec_rs = rs; dec_rs_v = rs_v; dec_rt = rt; dec_rt_v = rt_v;
        dec_rd = rd;    dec_rd_v = rd_v; dec_memread = mr; dec_jump = jmp;
    endtask

    task automatic nop_d();
        set_d(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        branch_taken_e = 1'b0;
        dmem_stall = 1'b1;
        set_d(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);
        mid(); chk("reset_gate_fwd", oa, O_NONE);
        chk("reset_gate_nofwd", ob, O_NONE);
        dmem_stall = 1'b0;
        nop_d();
        tick(); rst_n = 1'b1;
        mid(); chk("after_reset", oa, O_NONE);
        tick();

        // Load-use with forwarding
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        mid(); chk("lu_load", oa, O_NONE);
        tick();
        set_d(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        mid(); chk("lu_stall", oa, O_RAW);
        tick();
        mid(); chk("lu_release", oa, O_NONE);
        tick();
        set_d(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
        mid(); chk("self_nomatch", oa, O_NONE);
        tick();
        set_d(1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        mid(); chk("lu_rt", oa, O_RAW);
        tick();
        set_d(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
        mid(); chk("indep_rs4", oa, O_NONE);
        tick();

        // Branch overrides load-use
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        mid(); chk("br_load", oa, O_NONE);
        tick();
        set_d(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        branch_taken_e = 1'b1;
        mid(); chk("br_override", oa, O_BR);
        tick();
        branch_taken_e = 1'b0;
        mid(); chk("br_after", oa, O_NONE);
        tick();

        // Memory stall holds the shadow
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        mid(); chk("ms_load", oa, O_NONE);
        tick();
        set_d(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        dmem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid(); chk($sformatf("ms_hold%0d", i), oa, O_MEM);
            tick();
        end
        dmem_stall = 1'b0;
        mid(); chk("ms_lu_after", oa, O_RAW);
        tick();
        mid(); chk("ms_release", oa, O_NONE);
        tick();
        nop_d();
        tick();

        // Jump bubbles
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        mid(); chk("jmp_idle", oa, O_NONE);
        tick(); nop_d();
        mid(); chk("jmp_b1", oa, O_NOP);
        tick();
        mid(); chk("jmp_b2", oa, O_NOP);
        tick();
        mid(); chk("jmp_done", oa, O_NONE);
        tick();

        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick(); nop_d();
        mid(); chk("jms_b1", oa, O_NOP);
        tick(); dmem_stall = 1'b1;
        mid(); chk("jms_stalled", oa, O_MEM);
        tick(); dmem_stall = 1'b0;
        mid(); chk("jms_b2", oa, O_NOP);
        tick();
        mid(); chk("jms_done", oa, O_NONE);
        tick();

        // Jump held by load-use until it issues
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        tick();
        set_d(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        mid(); chk("jr_blocked", oa, O_RAW);
        tick();
        mid(); chk("jr_issue", oa, O_NONE);
        tick(); nop_d();
        mid(); chk("jr_bubble", oa, O_NOP);
        tick(); tick(); tick();

        // No forwarding: ALU result in SE then SM stalls, WB bypassed
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        mid(); chk("nf_writer", ob, O_NONE);
        tick();
        set_d(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0);
        mid(); chk("nf_hit_se", ob, O_RAW);
        chk("fw_no_alu_stall", oa, O_NONE);
        tick();
        mid(); chk("nf_hit_sm", ob, O_RAW);
        tick();
        mid(); chk("nf_issue", ob, O_NONE);
        tick();
        nop_d();
        tick();

        // Asynchronous reset mid-bubble
        set_d(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick(); nop_d();
        #1; chk("ar_bubble", oa, O_NOP);
        rst_n = 1'b0;
        #1; chk("ar_async_fwd", oa, O_NONE);
        chk("ar_async_nofwd", ob, O_NONE);
        tick(); rst_n = 1'b1;
        mid(); chk("ar_post1", oa, O_NONE);
        tick();
        mid(); chk("ar_post2", oa, O_NONE);
        chk("ar_post2_nofwd", ob, O_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
